// File: rtl/mallet_keypad_scanner_pkg.sv
// mallet_keypad_scanner_pkg: shared state encoding, key width and frame-result type
package mallet_keypad_scanner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CONFIRM = 2'd1, PRESSED = 2'd2, RELEASE = 2'd3} state_t;
  localparam int KEY_W = 4;
  localparam logic [3:0] COL_RESET = 4'b1110;
  // All 16 codes are real keys, so "no key" travels as a separate hit bit.
  typedef struct packed {
    logic hit;
    logic [KEY_W-1:0] key;
  } frame_t;
endpackage

// File: rtl/keypad_column_scanner.sv
// keypad_column_scanner: drives columns, priority-encodes rows and reports one result per frame
module keypad_column_scanner
  import mallet_keypad_scanner_pkg::*;
#(
  parameter int SCAN_PERIOD = 1000
) (
  input  logic             clk_1us,
  input  logic             reset,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic             frame_event,
  output logic             frame_hit,
  output logic [KEY_W-1:0] frame_key
);
  localparam int CW = $clog2(SCAN_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(SCAN_PERIOD - 1);
  logic [CW-1:0] cnt;
  logic [1:0] col, row_idx;
  logic sample;
  frame_t acc, cur, merged;
  assign row_idx = !row_n[0] ? 2'd0 : !row_n[1] ? 2'd1 : !row_n[2] ? 2'd2 : 2'd3;
  assign sample = cnt == LAST;
  assign cur = {~&row_n, col, row_idx};
  // Column 0 starts a fresh frame; later columns only win if nothing earlier hit.
  assign merged = (col != 2'd0 && acc.hit) ? acc : cur;
  assign frame_event = sample && col == 2'd3;
  assign frame_hit = merged.hit;
  assign frame_key = merged.key;
  always_ff @(posedge clk_1us) begin
    if (!reset) begin
      cnt <= '0;
      col <= 2'd0;
      col_n <= COL_RESET;
      acc <= '0;
    end else begin
      cnt <= sample ? '0 : cnt + 1'b1;
      if (sample) begin
        col <= col + 2'd1;
        col_n <= {col_n[2:0], col_n[3]};
        acc <= merged;
      end
    end
  end
endmodule

// File: rtl/mallet_keypad_scanner.sv
// mallet_keypad_scanner: debounced 4x4 keypad to mallet position plus one-cycle press strobe
module mallet_keypad_scanner
  import mallet_keypad_scanner_pkg::*;
#(
  parameter int SCAN_PERIOD = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic             clk_1us,
  input  logic             reset,
  input  logic [3:0]       row_n,
  output logic [3:0]       col_n,
  output logic [KEY_W-1:0] mallet_position,
  output logic             PRESS_VALID,
  output logic             key_held
);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DF = DW'(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] ONE = DW'(1);
  state_t state, state_nx;
  logic [KEY_W-1:0] cand, cand_nx, frame_key;
  logic [DW-1:0] cnt, cnt_nx, cnt_inc;
  logic frame_event, frame_hit, accept;
  keypad_column_scanner #(.SCAN_PERIOD(SCAN_PERIOD)) u_scan (
    .clk_1us(clk_1us),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .frame_event(frame_event),
    .frame_hit(frame_hit),
    .frame_key(frame_key)
  );
  assign cnt_inc = cnt + 1'b1;
  assign key_held = state == PRESSED || state == RELEASE;
  always_comb begin
    state_nx = state;
    cand_nx = cand;
    cnt_nx = cnt;
    accept = 1'b0;
    if (frame_event)
      case (state)
        IDLE:
          if (frame_hit) begin
            cand_nx = frame_key;
            cnt_nx = ONE;
            state_nx = DF == ONE ? PRESSED : CONFIRM;
            accept = DF == ONE;
          end
        CONFIRM:
          if (!frame_hit) state_nx = IDLE;
          else if (frame_key != cand) begin
            cand_nx = frame_key;
            cnt_nx = ONE;
          end else if (cnt_inc == DF) begin
            state_nx = PRESSED;
            accept = 1'b1;
          end else cnt_nx = cnt_inc;
        PRESSED:
          if (!frame_hit) begin
            cnt_nx = ONE;
            state_nx = DF == ONE ? IDLE : RELEASE;
          end
        RELEASE:
          if (frame_hit) state_nx = PRESSED;
          else if (cnt_inc == DF) state_nx = IDLE;
          else cnt_nx = cnt_inc;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk_1us) begin
    if (!reset) begin
      state <= IDLE;
      cand <= '0;
      cnt <= '0;
      mallet_position <= '0;
      PRESS_VALID <= 1'b0;
    end else begin
      state <= state_nx;
      cand <= cand_nx;
      cnt <= cnt_nx;
      PRESS_VALID <= accept;
      if (accept) mallet_position <= cand_nx;
    end
  end
endmodule

// File: tb/tb_mallet_keypad_scanner.sv
// tb_mallet_keypad_scanner: table-driven and randomized checks against a frame-level keypad model
module tb_mallet_keypad_scanner;
  localparam int DF = 3;
  localparam logic [15:0] K1 = 16'h0002, K3 = 16'h0008, K4 = 16'h0010, K5 = 16'h0020;
  localparam logic [15:0] K6 = 16'h0040, K9 = 16'h0200, K10 = 16'h0400;
  logic clk_1us = 1'b0, reset = 1'b0, PRESS_VALID, key_held;
  logic [3:0] row_n, col_n, mallet_position;
  logic [15:0] keys = '0;
  int n_chk = 0, n_fail = 0;
  logic m_held, m_pv, m_run_hit;
  logic [3:0] m_pos, m_run_key;
  int m_run_len;
  typedef struct {
    logic [15:0] keys;
    logic pulse;
    logic [3:0] pos;
    logic held;
  } vec_t;
  vec_t tbl[$];
  always #5 clk_1us = ~clk_1us;
  mallet_keypad_scanner #(.SCAN_PERIOD(4), .DEBOUNCE_FRAMES(DF)) dut (
    .clk_1us(clk_1us),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .mallet_position(mallet_position),
    .PRESS_VALID(PRESS_VALID),
    .key_held(key_held)
  );
  // Physical keypad: a pressed key shorts its row to its driven-low column.
  always_comb begin
    row_n = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_n[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4+r]) row_n[r] = 1'b0;
  end
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask
  task automatic model_reset();
    m_held = 1'b0;
    m_pv = 1'b0;
    m_pos = '0;
    m_run_len = 0;
    m_run_hit = 1'b0;
    m_run_key = '0;
  endtask
  // Lowest set code wins; press/release need DF identical consecutive frames.
  task automatic model_frame(input logic [15:0] m);
    logic hit;
    logic [3:0] key;
    hit = m != 0;
    key = '0;
    for (int k = 15; k >= 0; k--) if (m[k]) key = 4'(k);
    if (m_run_len > 0 && hit == m_run_hit && key == m_run_key) m_run_len++;
    else begin
      m_run_hit = hit;
      m_run_key = key;
      m_run_len = 1;
    end
    m_pv = 1'b0;
    if (!m_held && hit && m_run_len == DF) begin
      m_held = 1'b1;
      m_pos = key;
      m_pv = 1'b1;
    end else if (m_held && !hit && m_run_len == DF) m_held = 1'b0;
  endtask
  task automatic check_cycle(input int i);
    check("col_n", {12'h0, col_n}, {12'h0, 4'hF ^ (4'h1 << (i / 4))});
    check("press_valid", {15'h0, PRESS_VALID}, {15'h0, i == 0 ? m_pv : 1'b0});
    check("mallet_position", {12'h0, mallet_position}, {12'h0, m_pos});
    check("key_held", {15'h0, key_held}, {15'h0, m_held});
  endtask
  task automatic run_frame(input logic [15:0] m, input int len);
    keys = m;
    for (int i = 0; i < len; i++) begin
      check_cycle(i);
      if (i == 15) model_frame(m);
      @(posedge clk_1us);
      #1;
    end
  endtask
  task automatic add(input logic [15:0] k, input logic p, input logic [3:0] pos, input logic h);
    tbl.push_back('{keys: k, pulse: p, pos: pos, held: h});
  endtask
  task automatic add_n(input logic [15:0] k, input int n, input logic [3:0] pos, input logic h);
    repeat (n) add(k, 1'b0, pos, h);
  endtask
  initial begin
    logic [15:0] m;
    add_n(0, 3, 0, 0);
    add_n(K6, 2, 0, 0); add(0, 0, 0, 0); add_n(K6, 2, 0, 0); add(0, 0, 0, 0);
    add_n(K6, 2, 0, 0); add(K6, 1, 6, 1); add_n(K6, 10, 6, 1); add_n(0, 2, 6, 1); add(0, 0, 6, 0);
    add_n(K9 | K3, 2, 6, 0); add(K9 | K3, 1, 3, 1); add(K9 | K3, 0, 3, 1); add_n(0, 2, 3, 1); add(0, 0, 3, 0);
    add_n(K5, 2, 3, 0); add(K5, 1, 5, 1); add_n(0, 2, 5, 1); add(K5, 0, 5, 1);
    add_n(0, 2, 5, 1); add(0, 0, 5, 0); add_n(K5, 2, 5, 0); add(K5, 1, 5, 1); add_n(0, 2, 5, 1); add(0, 0, 5, 0);
    add_n(K10, 2, 5, 0); add(K10, 1, 10, 1); add_n(K1, 2, 10, 1); add_n(0, 2, 10, 1); add(0, 0, 10, 0);
    model_reset();
    repeat (3) @(posedge clk_1us);
    #1;
    reset = 1'b1;
    foreach (tbl[k]) begin
      run_frame(tbl[k].keys, 16);
      check("tbl_pulse", {15'h0, PRESS_VALID}, {15'h0, tbl[k].pulse});
      check("tbl_position", {12'h0, mallet_position}, {12'h0, tbl[k].pos});
      check("tbl_held", {15'h0, key_held}, {15'h0, tbl[k].held});
    end
    run_frame(K4, 16);
    run_frame(K4, 16);
    run_frame(K4, 5);
    reset = 1'b0;
    @(posedge clk_1us);
    #1;
    reset = 1'b1;
    model_reset();
    check("rst_col_n", {12'h0, col_n}, 16'h000E);
    check("rst_pulse", {15'h0, PRESS_VALID}, 16'h0);
    check("rst_position", {12'h0, mallet_position}, 16'h0);
    check("rst_held", {15'h0, key_held}, 16'h0);
    run_frame(K4, 16);
    run_frame(K4, 16);
    check("rst_no_early_pulse", {15'h0, PRESS_VALID}, 16'h0);
    run_frame(K4, 16);
    check("rst_fresh_pulse", {15'h0, PRESS_VALID}, 16'h1);
    check("rst_fresh_position", {12'h0, mallet_position}, 16'h4);
    repeat (3) run_frame(0, 16);
    repeat (60) begin
      case ($urandom_range(0, 3))
        0: m = '0;
        3: m = 16'($urandom);
        default: m = 16'h1 << $urandom_range(0, 15);
      endcase
      repeat ($urandom_range(1, 4)) run_frame(m, 16);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
